// File: rtl/id_stage.sv
// id_stage: MIPS decode stage with writeback bypass, load-use stall and a
// valid/ready handshake toward execute.
// Ports: clk, rst (async, active-low), if_* fetch handshake,
// rs/rt register file read, wb_* writeback, flush, ex_* registered ID/EX
// payload.
module id_stage #(
    parameter int ADDR  = 5,
    parameter int BUS_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    input  logic [BUS_W-1:0] if_instr,
    output logic             if_ready,
    output logic [ADDR-1:0]  rs_addr,
    output logic [ADDR-1:0]  rt_addr,
    input  logic [BUS_W-1:0] rs_data,
    input  logic [BUS_W-1:0] rt_data,
    input  logic             wb_write,
    input  logic [ADDR-1:0]  wb_addr,
    input  logic [BUS_W-1:0] wb_data,
    input  logic             flush,
    input  logic             ex_ready,
    output logic             ex_valid,
    output logic [BUS_W-1:0] ex_op_a,
    output logic [BUS_W-1:0] ex_op_b,
    output logic [BUS_W-1:0] ex_imm,
    output logic [5:0]       ex_opcode,
    output logic [5:0]       ex_funct,
    output logic [ADDR-1:0]  ex_rd_addr,
    output logic             ex_reg_write,
    output logic             ex_mem_read
);

    typedef enum logic {RUN, STALL} state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [BUS_W-1:0]   op_a_q, op_a_d;
    logic [BUS_W-1:0]   op_b_q, op_b_d;
    logic [BUS_W-1:0]   imm_q, imm_d;
    logic [5:0]         opc_q, opc_d;
    logic [5:0]         fn_q, fn_d;
    logic [ADDR-1:0]    rd_q, rd_d;
    logic               rw_q, rw_d;
    logic               mr_q, mr_d;
    logic               last_load_q, last_load_d;
    logic [ADDR-1:0]    last_rt_q, last_rt_d;

    logic [5:0]         opcode;
    logic [5:0]         funct;
    logic [ADDR-1:0]    dest;
    logic [BUS_W-1:0]   fwd_a;
    logic [BUS_W-1:0]   fwd_b;
    logic [BUS_W-1:0]   imm_ext;
    logic               dec_rw;
    logic               dec_mr;
    logic               advance;
    logic               hazard;
    logic               accept;

    assign opcode  = if_instr[31:26];
    assign funct   = if_instr[5:0];
    assign rs_addr = if_instr[21 +: ADDR];
    assign rt_addr = if_instr[16 +: ADDR];
    assign dest    = (opcode == 6'h00) ? if_instr[11 +: ADDR]
                                       : if_instr[16 +: ADDR];

    // $0 reads as zero; a same-cycle writeback wins over the stale file value.
    assign fwd_a = (rs_addr == '0) ? '0 :
                   (wb_write && wb_addr == rs_addr) ? wb_data : rs_data;
    assign fwd_b = (rt_addr == '0) ? '0 :
                   (wb_write && wb_addr == rt_addr) ? wb_data : rt_data;

    // andi/ori take a zero-extended immediate, everything else sign-extends.
    assign imm_ext = (opcode == 6'h0C || opcode == 6'h0D)
                   ? {{(BUS_W-16){1'b0}}, if_instr[15:0]}
                   : {{(BUS_W-16){if_instr[15]}}, if_instr[15:0]};

    always_comb begin
        dec_rw = 1'b0;
        case (opcode)
            6'h00:   dec_rw = (funct != 6'h08);
            6'h08,
            6'h0A,
            6'h0C,
            6'h0D,
            6'h0F,
            6'h23:   dec_rw = 1'b1;
            default: dec_rw = 1'b0;
        endcase
        if (dest == '0) dec_rw = 1'b0;
    end

    assign dec_mr = (opcode == 6'h23);

    assign advance = !valid_q || ex_ready;
    assign hazard  = last_load_q && (last_rt_q != '0) &&
                     (last_rt_q == rs_addr || last_rt_q == rt_addr);
    assign if_ready = advance && (state_q == RUN) && !hazard && !flush;
    assign accept   = if_valid && if_ready;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        imm_d       = imm_q;
        opc_d       = opc_q;
        fn_d        = fn_q;
        rd_d        = rd_q;
        rw_d        = rw_q;
        mr_d        = mr_q;
        last_load_d = last_load_q;
        last_rt_d   = last_rt_q;
        if (flush) begin
            valid_d     = 1'b0;
            state_d     = RUN;
            last_load_d = 1'b0;
        end else if (accept) begin
            valid_d     = 1'b1;
            op_a_d      = fwd_a;
            op_b_d      = fwd_b;
            imm_d       = imm_ext;
            opc_d       = opcode;
            fn_d        = funct;
            rd_d        = dest;
            rw_d        = dec_rw;
            mr_d        = dec_mr;
            last_load_d = dec_mr;
            last_rt_d   = rt_addr;
        end else if (advance) begin
            // Bubble: nothing issued this cycle.
            valid_d     = 1'b0;
            last_load_d = 1'b0;
            case (state_q)
                RUN:     if (if_valid && hazard) state_d = STALL;
                STALL:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            valid_q     <= 1'b0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            imm_q       <= '0;
            opc_q       <= '0;
            fn_q        <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            mr_q        <= 1'b0;
            last_load_q <= 1'b0;
            last_rt_q   <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            imm_q       <= imm_d;
            opc_q       <= opc_d;
            fn_q        <= fn_d;
            rd_q        <= rd_d;
            rw_q        <= rw_d;
            mr_q        <= mr_d;
            last_load_q <= last_load_d;
            last_rt_q   <= last_rt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_op_a      = op_a_q;
    assign ex_op_b      = op_b_q;
    assign ex_imm       = imm_q;
    assign ex_opcode    = opc_q;
    assign ex_funct     = fn_q;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = rw_q;
    assign ex_mem_read  = mr_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed and randomized checks of id_stage against a
// behavioural decode/handshake model.
module tb_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic [31:0] if_instr = '0;
    logic [31:0] rs_data = '0;
    logic [31:0] rt_data = '0;
    logic        wb_write = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b1;

    logic        if_ready;
    logic [4:0]  rs_addr, rt_addr;
    logic        ex_valid;
    logic [31:0] ex_op_a, ex_op_b, ex_imm;
    logic [5:0]  ex_opcode, ex_funct;
    logic [4:0]  ex_rd_addr;
    logic        ex_reg_write, ex_mem_read;

    int checks = 0;
    int failures = 0;

    id_stage #(.ADDR(5), .BUS_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .rs_data(rs_data), .rt_data(rt_data),
        .wb_write(wb_write), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush), .ex_ready(ex_ready),
        .ex_valid(ex_valid), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b),
        .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_funct(ex_funct),
        .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // Reference model: issued payload plus the pipeline bookkeeping
    // (pending load target and whether a stall cycle is owed).
    logic        m_valid, m_stall, m_lload;
    logic [4:0]  m_lrt;
    logic [31:0] m_a, m_b, m_imm;
    logic [5:0]  m_op, m_fn;
    logic [4:0]  m_rd;
    logic        m_rw, m_mr;

    function automatic logic [31:0] operand(input logic [4:0] a,
                                            input logic [31:0] rf);
        if (a == 0) return 32'd0;
        if (wb_write && wb_addr == a) return wb_data;
        return rf;
    endfunction

    function automatic logic m_hazard();
        return m_lload && m_lrt != 0 &&
               (m_lrt == if_instr[25:21] || m_lrt == if_instr[20:16]);
    endfunction

    function automatic logic m_ready();
        return (!m_valid || ex_ready) && !m_stall && !m_hazard() && !flush;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_stall = 0; m_lload = 0; m_lrt = 0;
        m_a = 0; m_b = 0; m_imm = 0; m_op = 0; m_fn = 0;
        m_rd = 0; m_rw = 0; m_mr = 0;
    endtask

    task automatic model_step();
        logic [5:0] op;
        logic adv;
        op = if_instr[31:26];
        adv = !m_valid || ex_ready;
        if (flush) begin
            m_valid = 0; m_stall = 0; m_lload = 0;
        end else if (if_valid && m_ready()) begin
            m_valid = 1;
            m_a = operand(if_instr[25:21], rs_data);
            m_b = operand(if_instr[20:16], rt_data);
            if (op == 6'h0C || op == 6'h0D)
                m_imm = {16'h0, if_instr[15:0]};
            else
                m_imm = {{16{if_instr[15]}}, if_instr[15:0]};
            m_op = op;
            m_fn = if_instr[5:0];
            m_rd = (op == 0) ? if_instr[15:11] : if_instr[20:16];
            m_rw = (op == 0 && if_instr[5:0] != 6'h08) ||
                   op == 6'h08 || op == 6'h0A || op == 6'h0C ||
                   op == 6'h0D || op == 6'h0F || op == 6'h23;
            if (m_rd == 0) m_rw = 0;
            m_mr = (op == 6'h23);
            m_lload = m_mr;
            m_lrt = if_instr[20:16];
        end else if (adv) begin
            if (m_stall) m_stall = 0;
            else if (if_valid && m_hazard()) m_stall = 1;
            m_valid = 0;
            m_lload = 0;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({ex_valid, ex_reg_write, ex_mem_read} !== 3'b000 ||
            ex_op_a !== 0 || ex_op_b !== 0 || ex_imm !== 0 ||
            ex_rd_addr !== 0 || ex_opcode !== 0 || ex_funct !== 0) begin
            failures++;
            $display("FAIL reset_state: valid=%b rw=%b mr=%b a=%h b=%h imm=%h rd=%0d want all 0",
                     ex_valid, ex_reg_write, ex_mem_read, ex_op_a, ex_op_b, ex_imm, ex_rd_addr);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if (if_ready !== 1'b1 || ex_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: if_ready=%b ex_valid=%b want 1/0", if_ready, ex_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_add_forward();
        logic [31:0] want_a [3];
        logic [31:0] instr [3];
        logic        wbw [3];
        logic [4:0]  wba [3];
        want_a = '{32'hAA, 32'd5, 32'd0};
        instr  = '{32'h00221820, 32'h00221820, 32'h00021820};
        wbw    = '{1'b1, 1'b1, 1'b0};
        wba    = '{5'd1, 5'd0, 5'd0};
        if_valid = 1; if_instr = 32'h00221820;
        rs_data = 5; rt_data = 7; ex_ready = 1; wb_write = 0;
        #1;
        checks++;
        if (rs_addr !== 5'd1 || rt_addr !== 5'd2 || if_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_addr: rs=%0d rt=%0d rdy=%b want 1 2 1", rs_addr, rt_addr, if_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 1 || ex_op_a !== 5 || ex_op_b !== 7 ||
            ex_rd_addr !== 3 || ex_reg_write !== 1 || ex_mem_read !== 0 ||
            ex_opcode !== 0 || ex_funct !== 6'h20) begin
            failures++;
            $display("FAIL add_basic: v=%b a=%h b=%h rd=%0d rw=%b mr=%b want 1 5 7 3 1 0",
                     ex_valid, ex_op_a, ex_op_b, ex_rd_addr, ex_reg_write, ex_mem_read);
        end
        for (int i = 0; i < 3; i++) begin
            if_instr = instr[i];
            wb_write = wbw[i]; wb_addr = wba[i]; wb_data = 32'hAA;
            tick();
            checks++;
            if (ex_valid !== 1 || ex_op_a !== want_a[i] || ex_op_b !== 7) begin
                failures++;
                $display("FAIL add_forward_%0d: v=%b a=%h b=%h want 1 %h 7",
                         i, ex_valid, ex_op_a, ex_op_b, want_a[i]);
            end
        end
        wb_write = 0; if_valid = 0;
        tick();
    endtask

    task automatic test_imm();
        logic [31:0] instr [2];
        logic [31:0] want [2];
        instr = '{32'h2002FFFF, 32'h3402FFFF};
        want  = '{32'hFFFFFFFF, 32'h0000FFFF};
        ex_ready = 1;
        for (int i = 0; i < 2; i++) begin
            if_valid = 1; if_instr = instr[i];
            tick();
            checks++;
            if (ex_valid !== 1 || ex_imm !== want[i] ||
                ex_rd_addr !== 2 || ex_reg_write !== 1) begin
                failures++;
                $display("FAIL imm_%0d: v=%b imm=%h rd=%0d rw=%b want 1 %h 2 1",
                         i, ex_valid, ex_imm, ex_rd_addr, ex_reg_write, want[i]);
            end
        end
        if_valid = 0;
        tick();
    endtask

    task automatic test_load_use();
        ex_ready = 1;
        if_valid = 1; if_instr = 32'h8C240000;
        rs_data = 32'h100; rt_data = 32'h9;
        tick();
        checks++;
        if (ex_valid !== 1 || ex_mem_read !== 1 || ex_rd_addr !== 4 ||
            ex_reg_write !== 1 || ex_op_a !== 32'h100) begin
            failures++;
            $display("FAIL lw_issue: v=%b mr=%b rd=%0d rw=%b a=%h want 1 1 4 1 100",
                     ex_valid, ex_mem_read, ex_rd_addr, ex_reg_write, ex_op_a);
        end
        if_instr = 32'h00842820;
        #1;
        checks++;
        if (if_ready !== 0) begin
            failures++;
            $display("FAIL lu_hazard_ready: if_ready=%b want 0", if_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 0 || if_ready !== 0) begin
            failures++;
            $display("FAIL lu_bubble: ex_valid=%b if_ready=%b want 0 0", ex_valid, if_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 0 || if_ready !== 1) begin
            failures++;
            $display("FAIL lu_resume: ex_valid=%b if_ready=%b want 0 1", ex_valid, if_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 1 || ex_rd_addr !== 5 || ex_mem_read !== 0 ||
            ex_funct !== 6'h20) begin
            failures++;
            $display("FAIL lu_add_issue: v=%b rd=%0d mr=%b fn=%h want 1 5 0 20",
                     ex_valid, ex_rd_addr, ex_mem_read, ex_funct);
        end
        if_valid = 0;
        tick();
    endtask

    task automatic test_backpressure();
        ex_ready = 1; rs_data = 5; rt_data = 7;
        if_valid = 1; if_instr = 32'h00221820;
        tick();
        ex_ready = 0; if_instr = 32'h2002FFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (if_ready !== 0) begin
                failures++;
                $display("FAIL bp_ready_%0d: if_ready=%b want 0", i, if_ready);
            end
            tick();
            checks++;
            if (ex_valid !== 1 || ex_op_a !== 5 || ex_op_b !== 7 ||
                ex_rd_addr !== 3 || ex_imm !== 32'h1820) begin
                failures++;
                $display("FAIL bp_hold_%0d: v=%b a=%h b=%h rd=%0d imm=%h want 1 5 7 3 1820",
                         i, ex_valid, ex_op_a, ex_op_b, ex_rd_addr, ex_imm);
            end
        end
        ex_ready = 1;
        #1;
        checks++;
        if (if_ready !== 1) begin
            failures++;
            $display("FAIL bp_release: if_ready=%b want 1", if_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 1 || ex_imm !== 32'hFFFFFFFF || ex_rd_addr !== 2) begin
            failures++;
            $display("FAIL bp_drain: v=%b imm=%h rd=%0d want 1 ffffffff 2",
                     ex_valid, ex_imm, ex_rd_addr);
        end
        if_valid = 0;
        tick();
        checks++;
        if (ex_valid !== 0) begin
            failures++;
            $display("FAIL bp_empty: ex_valid=%b want 0", ex_valid);
        end
    endtask

    task automatic test_flush_reset();
        ex_ready = 1;
        if_valid = 1; if_instr = 32'h8C240000;
        tick();
        if_instr = 32'h00842820;
        tick();
        flush = 1;
        #1;
        checks++;
        if (if_ready !== 0) begin
            failures++;
            $display("FAIL flush_ready: if_ready=%b want 0", if_ready);
        end
        tick();
        flush = 0;
        #1;
        checks++;
        if (ex_valid !== 0 || if_ready !== 1) begin
            failures++;
            $display("FAIL flush_stall: ex_valid=%b if_ready=%b want 0 1", ex_valid, if_ready);
        end
        tick();
        checks++;
        if (ex_valid !== 1 || ex_rd_addr !== 5) begin
            failures++;
            $display("FAIL flush_reissue: v=%b rd=%0d want 1 5", ex_valid, ex_rd_addr);
        end
        // Async reset while a payload is in the output register.
        #2 rst = 0;
        #1;
        model_reset();
        checks++;
        if (ex_valid !== 0 || ex_reg_write !== 0 || ex_op_a !== 0 || ex_rd_addr !== 0) begin
            failures++;
            $display("FAIL async_rst: v=%b rw=%b a=%h rd=%0d want 0 0 0 0",
                     ex_valid, ex_reg_write, ex_op_a, ex_rd_addr);
        end
        @(posedge clk);
        #1 rst = 1;
        if_valid = 0;
        #1;
        checks++;
        if (ex_valid !== 0 || if_ready !== 1) begin
            failures++;
            $display("FAIL rst_resume: ex_valid=%b if_ready=%b want 0 1", ex_valid, if_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [5:0]  ops [10];
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [15:0] im;
        ops = '{6'h00, 6'h00, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h23, 6'h2B};
        for (int n = 0; n < 600; n++) begin
            op = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            rs = 5'($urandom_range(0, 3));
            rt = 5'($urandom_range(0, 3));
            rd = 5'($urandom_range(0, 3));
            fn = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
            im = 16'($urandom);
            if_instr = (op == 0) ? {op, rs, rt, rd, 5'd0, fn} : {op, rs, rt, im};
            if_valid = ($urandom_range(0, 4) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 19) == 0);
            rs_data = $urandom; rt_data = $urandom;
            wb_write = $urandom_range(0, 1);
            wb_addr = 5'($urandom_range(0, 3));
            wb_data = $urandom;
            #1;
            checks++;
            if (if_ready !== m_ready() || rs_addr !== rs || rt_addr !== rt) begin
                failures++;
                $display("FAIL rnd_comb[%0d]: rdy=%b rs=%0d rt=%0d want %b %0d %0d",
                         n, if_ready, rs_addr, rt_addr, m_ready(), rs, rt);
            end
            tick();
            checks++;
            if (ex_valid !== m_valid) begin
                failures++;
                $display("FAIL rnd_valid[%0d]: ex_valid=%b want %b", n, ex_valid, m_valid);
            end else if (m_valid &&
                {ex_op_a, ex_op_b, ex_imm, ex_opcode, ex_funct, ex_rd_addr, ex_reg_write, ex_mem_read} !==
                {m_a, m_b, m_imm, m_op, m_fn, m_rd, m_rw, m_mr}) begin
                failures++;
                $display("FAIL rnd_payload[%0d]: a=%h b=%h imm=%h op=%h fn=%h rd=%0d rw=%b mr=%b want %h %h %h %h %h %0d %b %b",
                         n, ex_op_a, ex_op_b, ex_imm, ex_opcode, ex_funct, ex_rd_addr,
                         ex_reg_write, ex_mem_read, m_a, m_b, m_imm, m_op, m_fn, m_rd, m_rw, m_mr);
            end
        end
        flush = 0; if_valid = 0; ex_ready = 1; wb_write = 0;
        tick();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_add_forward();
        test_imm();
        test_load_use();
        test_backpressure();
        test_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
